// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC measurement sequencer.
// Optional min/max tracking is enabled with TDC_MINMAX_EN.
package tdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } tdc_smp_state_t;

  localparam int LOG_AVG_W = 4;

  function automatic int hw_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/tdc_multi_sampler_accum.sv
// Per-run sample datapath: clamp, accumulate, count, min/max.
// Min/max registers exist only when TDC_MINMAX_EN is defined.
module tdc_accum
  import tdc_pkg::*;
#(
  parameter int N_TAPS = 64,
  parameter int HW_W   = 7,
  parameter int ACC_W  = 15,
  parameter int CNT_W  = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [HW_W-1:0]  sample,
  output logic             over,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] acc_nxt,
  output logic [CNT_W-1:0] cnt,
  output logic [HW_W-1:0]  mn_nxt,
  output logic [HW_W-1:0]  mx_nxt
);

  localparam logic [HW_W-1:0] TAPS = HW_W'(N_TAPS);

  logic [HW_W-1:0] s;

  always_comb begin
    over    = sample > TAPS;
    s       = over ? TAPS : sample;
    acc_nxt = acc + ACC_W'(s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_en) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
    end
  end

`ifdef TDC_MINMAX_EN
  logic [HW_W-1:0] mn;
  logic [HW_W-1:0] mx;

  always_comb begin
    mn_nxt = (s < mn) ? s : mn;
    mx_nxt = (s > mx) ? s : mx;
  end

  // min starts at the full-scale value so the first sample always wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mn <= TAPS;
      mx <= '0;
    end else if (clear) begin
      mn <= TAPS;
      mx <= '0;
    end else if (sample_en) begin
      mn <= mn_nxt;
      mx <= mx_nxt;
    end
  end
`else
  assign mn_nxt = '0;
  assign mx_nxt = '0;
`endif

endmodule

// File: rtl/tdc_multi_sampler.sv
// Multi-channel TDC launch/settle/sample sequencer with averaging.
// Build with TDC_MINMAX_EN to report per-channel min/max.
module tdc_multi_sampler
  import tdc_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int N_TAPS      = 64,
  parameter int MAX_LOG_AVG = 8,
  parameter int SETTLE      = 3,
  localparam int HW_W  = hw_width(N_TAPS),
  localparam int ACC_W = HW_W + MAX_LOG_AVG,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 scan,
  input  logic [CH_W-1:0]      ch_sel,
  input  logic [LOG_AVG_W-1:0] log_avg,
  input  logic [N_CH*HW_W-1:0] hw_in,
  output logic [N_CH-1:0]      launch,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CH_W-1:0]      res_ch,
  output logic [ACC_W-1:0]     res_sum,
  output logic [HW_W-1:0]      res_mean,
  output logic [HW_W-1:0]      res_min,
  output logic [HW_W-1:0]      res_max,
  output logic                 err
);

  localparam int CNT_W = MAX_LOG_AVG + 1;
  localparam int SET_W = $clog2(SETTLE + 1);

  tdc_smp_state_t       state;
  tdc_smp_state_t       nxt;
  logic [CH_W-1:0]      ch;
  logic                 scan_q;
  logic [LOG_AVG_W-1:0] lavg;
  logic [LOG_AVG_W-1:0] lavg_c;
  logic [SET_W-1:0]     set_cnt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_tgt;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_nxt;
  logic [HW_W-1:0]      mn_nxt;
  logic [HW_W-1:0]      mx_nxt;
  logic [HW_W-1:0]      hw_sel;
  logic                 over;
  logic                 last;
  logic                 advance;
  logic                 clr;
  logic                 smp;
  logic                 go;
  logic                 adv;

  always_comb begin
    lavg_c  = (log_avg > LOG_AVG_W'(MAX_LOG_AVG))
            ? LOG_AVG_W'(MAX_LOG_AVG) : log_avg;
    hw_sel  = hw_in[int'(ch)*HW_W +: HW_W];
    cnt_tgt = (CNT_W'(1) << lavg) - CNT_W'(1);
    last    = cnt == cnt_tgt;
    advance = scan_q && (ch != CH_W'(N_CH - 1));
  end

  always_comb begin
    nxt = state;
    clr = 1'b0;
    smp = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          nxt = S_LAUNCH;
          clr = 1'b1;
        end
      end
      S_LAUNCH: nxt = S_WAIT;
      S_WAIT: begin
        if (set_cnt == '0) nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        smp = 1'b1;
        nxt = last ? S_DONE : S_LAUNCH;
      end
      S_DONE: begin
        if (res_ready) begin
          if (advance) begin
            clr = 1'b1;
            nxt = S_LAUNCH;
          end else begin
            nxt = S_IDLE;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
    // abort beats every in-flight action, including a handshake in DONE
    if (abort && state != S_IDLE) begin
      nxt = S_IDLE;
      clr = 1'b0;
      smp = 1'b0;
    end
  end

  assign go  = (state == S_IDLE) && (nxt == S_LAUNCH);
  assign adv = (state == S_DONE) && (nxt == S_LAUNCH);

  always_comb begin
    launch = '0;
    if (state == S_LAUNCH && !abort) launch[ch] = 1'b1;
  end

  assign busy      = state != S_IDLE;
  assign res_valid = state == S_DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ch       <= '0;
      scan_q   <= 1'b0;
      lavg     <= '0;
      set_cnt  <= '0;
      err      <= 1'b0;
      res_ch   <= '0;
      res_sum  <= '0;
      res_mean <= '0;
      res_min  <= '0;
      res_max  <= '0;
    end else begin
      state <= nxt;
      if (go) begin
        scan_q <= scan;
        ch     <= scan ? '0 : ch_sel;
        lavg   <= lavg_c;
        err    <= 1'b0;
      end
      if (adv) ch <= ch + 1'b1;
      if (state == S_LAUNCH) set_cnt <= SET_W'(SETTLE - 1);
      else if (state == S_WAIT) set_cnt <= set_cnt - 1'b1;
      if (smp && over) err <= 1'b1;
      if (smp && last) begin
        res_ch   <= ch;
        res_sum  <= acc_nxt;
        res_mean <= HW_W'(acc_nxt >> lavg);
        res_min  <= mn_nxt;
        res_max  <= mx_nxt;
      end
    end
  end

  tdc_accum #(
    .N_TAPS(N_TAPS),
    .HW_W  (HW_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clr),
    .sample_en(smp),
    .sample   (hw_sel),
    .over     (over),
    .acc      (acc),
    .acc_nxt  (acc_nxt),
    .cnt      (cnt),
    .mn_nxt   (mn_nxt),
    .mx_nxt   (mx_nxt)
  );

endmodule

// File: tb/tb_tdc_multi_sampler.sv
// Directed bench for tdc_multi_sampler: vector table plus corner sequences.
// Min/max expectations follow TDC_MINMAX_EN.
module tb_tdc_multi_sampler;

`ifdef TDC_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        scan;
  logic [1:0]  ch_sel;
  logic [3:0]  log_avg;
  logic [27:0] hw_in;
  logic [3:0]  launch;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_ch;
  logic [14:0] res_sum;
  logic [6:0]  res_mean;
  logic [6:0]  res_min;
  logic [6:0]  res_max;
  logic        err;

  logic [6:0]  hw_v [4];

  assign hw_in = {hw_v[3], hw_v[2], hw_v[1], hw_v[0]};

  always #5 clk = ~clk;

  tdc_multi_sampler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .scan     (scan),
    .ch_sel   (ch_sel),
    .log_avg  (log_avg),
    .hw_in    (hw_in),
    .launch   (launch),
    .busy     (busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_ch   (res_ch),
    .res_sum  (res_sum),
    .res_mean (res_mean),
    .res_min  (res_min),
    .res_max  (res_max),
    .err      (err)
  );

  typedef struct {
    bit scan;
    int ch;
    int lavg;
    int hw;
    int sum;
    int mean;
    int mn;
    int mx;
    bit err;
  } vec_t;

  int pass_n = 0;
  int tot_n  = 0;
  int lc[$];
  bit ramp_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int mm(input int v);
    return MM ? v : 0;
  endfunction

  task automatic set_all(input int v);
    for (int i = 0; i < 4; i++) hw_v[i] = 7'(v);
  endtask

  task automatic start_run(input bit sc, input int c, input int la);
    scan    = sc;
    ch_sel  = 2'(c);
    log_avg = 4'(la);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    lc.delete();
    while (!res_valid && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (launch != 0) begin
        lc.push_back(cyc);
        if (ramp_on) hw_v[2] = 7'(30 + lc.size());
      end
    end
    if (!res_valid) chk("timeout", 0, 1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int cyc;
    int eff;
    eff = (v.lavg > 8) ? 8 : v.lavg;
    set_all(v.hw);
    start_run(v.scan, v.ch, v.lavg);
    chk({nm, " launch0"}, int'(launch), 1 << v.ch);
    chk({nm, " err_clr"}, int'(err), 0);
    wait_valid(5 * (1 << eff) + 20, cyc);
    chk({nm, " latency"}, cyc, 5 * (1 << eff));
    chk({nm, " ch"}, int'(res_ch), v.ch);
    chk({nm, " sum"}, int'(res_sum), v.sum);
    chk({nm, " mean"}, int'(res_mean), v.mean);
    chk({nm, " min"}, int'(res_min), mm(v.mn));
    chk({nm, " max"}, int'(res_max), mm(v.mx));
    chk({nm, " err"}, int'(err), int'(v.err));
    accept();
    chk({nm, " idle"}, int'(busy), 0);
    chk({nm, " err_hold"}, int'(err), int'(v.err));
  endtask

  vec_t vecs[7];

  initial begin
    int cyc;
    int ok;

    vecs[0] = '{0, 1, 0,   5,     5,  5,  5,  5, 0};
    vecs[1] = '{0, 3, 3,  64,   512, 64, 64, 64, 0};
    vecs[2] = '{0, 0, 1, 100,   128, 64, 64, 64, 1};
    vecs[3] = '{0, 2, 12,  1,   256,  1,  1,  1, 0};
    vecs[4] = '{0, 1, 2,   0,     0,  0,  0,  0, 0};
    vecs[5] = '{0, 3, 0,  65,    64, 64, 64, 64, 1};
    vecs[6] = '{0, 0, 8, 127, 16384, 64, 64, 64, 1};

    start = 0; abort = 0; scan = 0; ch_sel = 0;
    log_avg = 0; res_ready = 0;
    set_all(0);
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst launch", int'(launch), 0);
    chk("rst valid", int'(res_valid), 0);
    chk("rst sum", int'(res_sum), 0);
    chk("rst err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ramped samples on channel 2
    set_all(0);
    hw_v[2] = 7'd30;
    ramp_on = 1'b1;
    start_run(0, 2, 2);
    chk("ramp launch0", int'(launch), 4);
    wait_valid(60, cyc);
    ramp_on = 1'b0;
    chk("ramp latency", cyc, 20);
    chk("ramp nlaunch", lc.size(), 3);
    if (lc.size() == 3) begin
      chk("ramp gap1", lc[0], 5);
      chk("ramp gap2", lc[1] - lc[0], 5);
      chk("ramp gap3", lc[2] - lc[1], 5);
    end
    chk("ramp sum", int'(res_sum), 126);
    chk("ramp mean", int'(res_mean), 31);
    chk("ramp min", int'(res_min), mm(30));
    chk("ramp max", int'(res_max), mm(33));
    chk("ramp ch", int'(res_ch), 2);
    accept();
    chk("ramp idle", int'(busy), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // scan with ready held high
    for (int i = 0; i < 4; i++) hw_v[i] = 7'(10 * (i + 1));
    res_ready = 1'b1;
    start_run(1, 3, 0);
    chk("scan launch0", int'(launch), 1);
    for (int k = 0; k < 4; k++) begin
      wait_valid(30, cyc);
      chk($sformatf("scan ch%0d", k), int'(res_ch), k);
      chk($sformatf("scan sum%0d", k), int'(res_sum), 10 * (k + 1));
      @(negedge clk);
    end
    res_ready = 1'b0;
    chk("scan idle", int'(busy), 0);

    // backpressure
    set_all(7);
    start_run(0, 1, 1);
    wait_valid(40, cyc);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid && res_sum == 15'd14 && res_ch == 2'd1 &&
          res_mean == 7'd7 && launch == 4'd0) ok++;
    end
    chk("bp stable", ok, 10);
    accept();
    chk("bp idle", int'(busy), 0);

    // start+abort together in idle
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa idle", int'(busy), 0);

    // abort during WAIT of third sample; stray start ignored
    set_all(5);
    start_run(0, 1, 2);
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) begin
        start  = 1'b1;
        scan   = 1'b1;
        ch_sel = 2'd3;
      end else begin
        start = 1'b0;
      end
      if (c == 6) chk("ab ignore", int'(launch), 2);
      if (c == 11) chk("ab third", int'(launch), 2);
    end
    chk("ab wait", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab idle", int'(busy), 0);
    chk("ab valid", int'(res_valid), 0);
    chk("ab launch", int'(launch), 0);
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!res_valid && !busy) ok++;
    end
    chk("ab quiet", ok, 8);
    chk("ab hold", int'(res_sum), 14);
    run_vec('{0, 2, 1, 9, 18, 9, 9, 9, 0}, "post_ab");

    // reset during a scan
    for (int i = 0; i < 4; i++) hw_v[i] = 7'(10 * (i + 1));
    start_run(1, 0, 0);
    wait_valid(30, cyc);
    accept();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst busy", int'(busy), 0);
    chk("mrst launch", int'(launch), 0);
    chk("mrst sum", int'(res_sum), 0);
    chk("mrst mean", int'(res_mean), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec('{0, 3, 9, 3, 768, 3, 3, 3, 0}, "clamp9");

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
